// File: rtl/downstream_cancel_reporter_if.sv
// RAM read port plus the report stream of the cancel reporter, bundled so the
// block and its environment connect through a single port each.
interface downstream_cancel_reporter_if #(
  parameter int IDX_W  = 10,
  parameter int DATA_W = 32
);
  logic [IDX_W-1:0]  rd_index;
  logic [DATA_W-1:0] rd_data;
  logic              rpt_valid;
  logic              rpt_ready;
  logic [IDX_W-1:0]  rpt_client;
  logic [DATA_W-1:0] rpt_delta;
  logic [DATA_W-1:0] rpt_total;
  logic              rpt_wrap;

  // Reporter side: drives the read address and the report record.
  modport master (
    output rd_index,
    input  rd_data,
    output rpt_valid,
    input  rpt_ready,
    output rpt_client,
    output rpt_delta,
    output rpt_total,
    output rpt_wrap
  );

  // Environment side: the RAM read port and the report consumer.
  modport slave (
    input  rd_index,
    output rd_data,
    input  rpt_valid,
    output rpt_ready,
    input  rpt_client,
    input  rpt_delta,
    input  rpt_total,
    input  rpt_wrap
  );
endinterface

// File: rtl/downstream_cancel_reporter.sv
// Sweeps every client entry of the cancel-accumulation RAM, compares each total
// with the last value reported for that client and emits one record per client
// whose total changed. Clients never reported before compare against zero.
module downstream_cancel_reporter #(
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  downstream_cancel_reporter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CMP,
    S_EMIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IDX_W-1:0]  r_index;
  logic [DATA_W-1:0] r_cur_total;
  logic [DATA_W-1:0] r_shadow [DEPTH];
  logic [DEPTH-1:0]  r_shadow_vld;

  logic              r_rpt_valid;
  logic [IDX_W-1:0]  r_rpt_client;
  logic [DATA_W-1:0] r_rpt_delta;
  logic [DATA_W-1:0] r_rpt_total;
  logic              r_rpt_wrap;
  logic              r_busy;
  logic              r_done;

  logic [DATA_W-1:0] w_shadow;
  logic [DATA_W-1:0] w_delta;
  logic              w_wrap;
  logic              w_accept;
  logic              w_last;
  logic              w_advance;
  logic              w_load_rpt;

  // A never-reported client reads as zero, so its first report carries the
  // full total as delta. A total below the shadow means the writer side was
  // cleared; report the new total itself rather than a huge modular delta.
  assign w_shadow = r_shadow_vld[r_index] ? r_shadow[r_index] : '0;
  assign w_wrap   = r_cur_total < w_shadow;
  assign w_delta  = w_wrap ? r_cur_total : r_cur_total - w_shadow;
  assign w_accept = r_rpt_valid & bus.rpt_ready;
  assign w_last   = (r_index == IDX_W'(DEPTH - 1));

  assign bus.rd_index   = r_index;
  assign bus.rpt_valid  = r_rpt_valid;
  assign bus.rpt_client = r_rpt_client;
  assign bus.rpt_delta  = r_rpt_delta;
  assign bus.rpt_total  = r_rpt_total;
  assign bus.rpt_wrap   = r_rpt_wrap;
  assign busy           = r_busy;
  assign done           = r_done;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode plus the advance / record-load strobes.
  // NOTE: every combinational output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    w_next     = r_state;
    w_advance  = 1'b0;
    w_load_rpt = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_READ;
      S_READ: w_next = S_CMP;
      S_CMP: begin
        if (w_delta == '0) begin
          w_advance = 1'b1;
          w_next    = w_last ? S_DONE : S_READ;
        end else begin
          w_load_rpt = 1'b1;
          w_next     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_accept) begin
          w_advance = 1'b1;
          w_next    = w_last ? S_DONE : S_READ;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Sweep index, sampled total, report record, shadow-valid bits and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index      <= '0;
      r_cur_total  <= '0;
      r_shadow_vld <= '0;
      r_rpt_valid  <= 1'b0;
      r_rpt_client <= '0;
      r_rpt_delta  <= '0;
      r_rpt_total  <= '0;
      r_rpt_wrap   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE && start) begin
        r_index <= '0;
        r_busy  <= 1'b1;
      end
      if (r_state == S_READ) r_cur_total <= bus.rd_data;
      if (r_state == S_DONE) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
      if (w_load_rpt) begin
        r_rpt_valid  <= 1'b1;
        r_rpt_client <= r_index;
        r_rpt_delta  <= w_delta;
        r_rpt_total  <= r_cur_total;
        r_rpt_wrap   <= w_wrap;
      end
      if (w_accept) begin
        r_rpt_valid           <= 1'b0;
        r_shadow_vld[r_index] <= 1'b1;
      end
      if (w_advance && !w_last) r_index <= r_index + 1'b1;
    end
  end

  // Shadow totals, written when a record is accepted.
  // NOTE: the array has no reset; the separately reset valid bits make stale
  // contents invisible, which keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (w_accept) r_shadow[r_index] <= r_cur_total;
  end

endmodule

// File: tb/tb_downstream_cancel_reporter.sv
// Directed bench for downstream_cancel_reporter: a small RAM model feeds the
// read port, expected records are queued by the stimulus and a monitor compares
// the presented record against the queue head on every falling edge.
module tb_downstream_cancel_reporter;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [IDX_W-1:0]  client;
    logic [DATA_W-1:0] delta;
    logic [DATA_W-1:0] total;
    logic              wrap;
  } rec_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  logic [DATA_W-1:0] ram [DEPTH];
  rec_t exp_q [$];
  rec_t got;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   t_start  = 0;

  downstream_cancel_reporter_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) bus_if ();

  downstream_cancel_reporter #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .busy (busy),
    .done (done),
    .bus  (bus_if.master)
  );

  assign bus_if.rd_data = ram[bus_if.rd_index];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input int c, input int d, input int t, input bit w);
    rec_t r;
    r.client = IDX_W'(c);
    r.delta  = DATA_W'(d);
    r.total  = DATA_W'(t);
    r.wrap   = w;
    return r;
  endfunction

  // Monitor: a presented record must match the queue head; it is retired on
  // handshake and re-compared every cycle while held.
  always @(negedge clk) begin
    if (!rst && bus_if.rpt_valid) begin
      got.client = bus_if.rpt_client;
      got.delta  = bus_if.rpt_delta;
      got.total  = bus_if.rpt_total;
      got.wrap   = bus_if.rpt_wrap;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_record: got %0h expected none", got);
      end else begin
        check(bus_if.rpt_ready ? "record" : "held_record", 128'(got), 128'(exp_q[0]));
        if (bus_if.rpt_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic start_sweep();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t_start = cyc;
    start   = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.rpt_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_valid_seen"}, 128'(seen), 128'(1));
  endtask

  task automatic wait_done(input string name, input int exp_cycles, input bit check_len);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 128'(seen), 128'(1));
    if (seen && check_len) check({name, "_cycles"}, 128'(cyc - t_start), 128'(exp_cycles));
    if (seen) check({name, "_busy_at_done"}, 128'(busy), 128'(0));
    @(posedge clk);
    #1;
    check({name, "_done_one_cycle"}, 128'(done), 128'(0));
    check({name, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    bus_if.rpt_ready = 1'b1;

    // Reset state.
    #12;
    check("rst_rpt_valid", 128'(bus_if.rpt_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_rd_index", 128'(bus_if.rd_index), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // 1: all-zero RAM, no records, 2*DEPTH+1 cycles.
    start_sweep();
    check("t1_busy", 128'(busy), 128'(1));
    wait_done("t1", 17, 1'b1);

    // 2: two new clients reported with full totals.
    ram[3] = 32'h10;
    ram[6] = 32'h200;
    exp_q.push_back(mk(3, 'h10, 'h10, 1'b0));
    exp_q.push_back(mk(6, 'h200, 'h200, 1'b0));
    start_sweep();
    wait_done("t2", 19, 1'b1);

    // 3: only the changed client reported, as a delta.
    ram[3] = 32'h25;
    exp_q.push_back(mk(3, 'h15, 'h25, 1'b0));
    start_sweep();
    wait_done("t3", 18, 1'b1);

    // 4: backpressure holds the record stable.
    ram[6] = 32'h280;
    bus_if.rpt_ready = 1'b0;
    exp_q.push_back(mk(6, 'h80, 'h280, 1'b0));
    start_sweep();
    wait_valid("t4");
    for (int i = 0; i < 5; i++) begin
      check("t4_valid_held", 128'(bus_if.rpt_valid), 128'(1));
      @(posedge clk);
      #1;
    end
    bus_if.rpt_ready = 1'b1;
    wait_done("t4", 0, 1'b0);

    // 5: total below shadow reports wrap with delta = total.
    ram[3] = 32'h05;
    exp_q.push_back(mk(3, 'h05, 'h05, 1'b1));
    start_sweep();
    wait_done("t5", 18, 1'b1);

    // 6: reset while client 6 waits in EMIT, then a full re-report.
    ram[6] = 32'h300;
    bus_if.rpt_ready = 1'b0;
    exp_q.push_back(mk(6, 'h80, 'h300, 1'b0));
    start_sweep();
    wait_valid("t6");
    check("t6_client", 128'(bus_if.rpt_client), 128'(6));
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", 128'(bus_if.rpt_valid), 128'(0));
    check("t6_async_busy", 128'(busy), 128'(0));
    check("t6_async_done", 128'(done), 128'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("t6_no_done", 128'(done), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    bus_if.rpt_ready = 1'b1;
    exp_q.push_back(mk(3, 'h05, 'h05, 1'b0));
    exp_q.push_back(mk(6, 'h300, 'h300, 1'b0));
    start_sweep();
    wait_done("t6", 19, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/downstream_cancel_reporter.md
Name: downstream_cancel_reporter

Overview:
- Read-side counterpart of the downstream cancel-accumulation RAM.
- The accumulation RAM adds each cancelled-order quantity into the entry indexed by client ID.
- This block sweeps every client ID through the RAM read port and compares each total with the last value it reported for that client.
- It emits one record per client whose total changed, carrying client ID, delta and new total, on a valid/ready stream to the downstream risk/reporting logic.

Parameters:
- DEPTH, 1024: number of client entries swept; must match the RAM depth.
- IDX_W, 10: client index width, clog2(DEPTH).
- DATA_W, 32: width of an accumulated total and of the delta.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- rd_index  out  IDX_W  read address to the RAM read port.
- rd_data  in  DATA_W  RAM read data; combinational from rd_index, same cycle.
- rpt_valid  out  1  report record valid.
- rpt_ready  in  1  consumer accepts the record.
- rpt_client  out  IDX_W  client ID of the record.
- rpt_delta  out  DATA_W  total minus last reported total.
- rpt_total  out  DATA_W  total sampled this sweep.
- rpt_wrap  out  1  total fell below the shadow value; delta equals total.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at the end of a sweep.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; index 0; all per-client shadow-valid bits 0.
- Shadow store: DEPTH x DATA_W array holding the last reported total per client.
  - No reset on the array itself.
  - An entry whose valid bit is 0 reads as 0.
- FSM states: IDLE, READ, CMP, EMIT, DONE.
- IDLE:
  - rd_index holds the index register.
  - On start=1, clear index to 0, set busy=1, go to READ.
- READ:
  - rd_index = index.
  - Register rd_data into cur_total; go to CMP.
- CMP:
  - Compute delta = cur_total - shadow[index], modulo 2^DATA_W.
  - If cur_total < shadow, set wrap=1 and delta = cur_total.
  - If delta = 0, advance; otherwise load the rpt_* registers and go to EMIT.
- EMIT:
  - rpt_valid=1, with payload stable until the handshake.
  - On rpt_valid & rpt_ready: write shadow[index] = cur_total, set the valid bit, drop rpt_valid the next cycle, advance.
  - rpt_ready while not valid has no effect.
- Advance:
  - If index = DEPTH-1, go to DONE.
  - Otherwise index+1 and go to READ.
- DONE: done=1 for exactly one cycle, busy=0, go to IDLE.
- Timing:
  - Minimum cost is 2 cycles per unchanged client and 3 cycles per reported client with rpt_ready held high.
  - A sweep with no changes takes 2*DEPTH+1 cycles from the start-sampled edge to done.
- start while busy is ignored; no queuing.
- A write landing on the current client after its READ cycle is not seen this sweep; it appears as delta in the next sweep.
- Totals never exceed 16'hffaa because of writer-side saturation. The block applies no saturation of its own and reports whatever it reads.
- Asynchronous reset mid-sweep:
  - Immediate return to IDLE, rpt_valid=0, done not pulsed.
  - All shadow-valid bits cleared, so the next sweep re-reports every nonzero total in full.

Test Plan:
1. DEPTH=8, RAM all zero, start -> no rpt_valid; done pulses exactly 17 cycles after the start edge; busy is 0 after done.
2. RAM[3]=0x10, RAM[6]=0x200, ready held 1, start -> records (3, 0x10, 0x10, wrap 0) then (6, 0x200, 0x200); done after 19 cycles.
3. Repeat sweep after RAM[3] becomes 0x25 -> single record (3, delta 0x15, total 0x25).
4. Backpressure: ready held 0 for 5 cycles while a record is valid -> rpt_valid and payload stable all 5 cycles; the record is accepted on the first ready cycle; nothing is duplicated and nothing is skipped.
5. RAM reloaded so RAM[3]=0x05 (shadow 0x25) -> record (3, 0x05, 0x05, wrap 1).
6. Assert rst while EMIT waits on client 6; release; rerun start -> rpt_valid drops asynchronously; the rerun reports every nonzero entry with full totals as deltas.
